// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg: definitions shared across the FP add/sub datapath.
//   - Exponent-compare codes produced by the exponent comparator and consumed
//     by the mantissa aligner.
//   - Aligner FSM state encoding.
//   - Default exponent / mantissa widths (mantissa includes the hidden bit).
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 24;

  // Compare codes: GREAT means exp_A < exp_B, SMALL means exp_A > exp_B.
  localparam logic [1:0] CMP_EQUAL = 2'b00;
  localparam logic [1:0] CMP_GREAT = 2'b01;
  localparam logic [1:0] CMP_SMALL = 2'b10;
  localparam logic [1:0] CMP_ERROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_e;

endpackage

// File: rtl/fp_mantissa_aligner_align_shift_step.sv
// -----------------------------------------------------------------------------
// align_shift_step: combinational single-bit logical right shift with sticky
// accumulate, used on the target-mantissa path of fp_mantissa_aligner.
//   man_in     : mantissa before this step
//   sticky_in  : OR of bits already shifted out
//   man_out    : man_in >> 1, zero filled
//   sticky_out : sticky_in OR the bit dropped by this step
// -----------------------------------------------------------------------------
module align_shift_step #(
  parameter int MAN_W = 24
) (
  input  logic [MAN_W-1:0] man_in,
  input  logic             sticky_in,
  output logic [MAN_W-1:0] man_out,
  output logic             sticky_out
);

  assign man_out    = {1'b0, man_in[MAN_W-1:1]};
  assign sticky_out = sticky_in | man_in[0];

endmodule

// File: rtl/fp_mantissa_aligner.sv
// -----------------------------------------------------------------------------
// fp_mantissa_aligner: aligns two FP mantissas to the larger exponent by
// right-shifting the smaller-exponent mantissa one bit per clock.
//
// Ports:
//   clk, rst_n                    : clock (rising edge), async active-low reset
//   in_valid / in_ready           : operand-set handshake (ready only in IDLE)
//   in_code                       : exponent-compare code from the comparator
//   in_exp_A/B, in_man_A/B        : operand exponents and mantissas
//   out_valid / out_ready         : aligned-result handshake
//   out_exp                       : common (larger) exponent, 0 on ERROR
//   out_man_A/B                   : aligned mantissas
//   out_err                       : input code was ERROR
//   out_sticky (ALIGN_STICKY_EN)  : OR of all bits shifted out of the target
//
// Configuration macro: ALIGN_STICKY_EN adds out_sticky; without it the
// shifted-out bits are simply discarded.
//
// Latency is n+1 cycles from presenting the input, n = min(diff, MAN_W).
// The compare code is trusted; exponents are never re-compared here.
// -----------------------------------------------------------------------------
module fp_mantissa_aligner
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  input  logic [EXP_W-1:0] in_exp_A,
  input  logic [EXP_W-1:0] in_exp_B,
  input  logic [MAN_W-1:0] in_man_A,
  input  logic [MAN_W-1:0] in_man_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man_A,
  output logic [MAN_W-1:0] out_man_B,
  output logic             out_err
`ifdef ALIGN_STICKY_EN
  ,
  output logic             out_sticky
`endif
);

  localparam int CNT_W = $clog2(MAN_W + 1);
  // MAN_W expressed one bit wider than an exponent so the saturation compare
  // never truncates either side.
  localparam logic [EXP_W:0] MAN_W_X = (EXP_W + 1)'(MAN_W);

  align_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic             target_a;   // 1: shift mantissa A, 0: shift mantissa B

  // Decode of the operand set presented in IDLE.
  logic [EXP_W-1:0] dec_diff;
  logic [EXP_W-1:0] dec_exp;
  logic             dec_target_a;
  logic             dec_err;
  logic [CNT_W-1:0] dec_cnt;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    dec_diff     = '0;
    dec_exp      = in_exp_A;
    dec_target_a = 1'b0;
    dec_err      = 1'b0;
    unique case (in_code)
      CMP_SMALL: begin
        dec_diff     = in_exp_A - in_exp_B;
        dec_target_a = 1'b0;
        dec_exp      = in_exp_A;
      end
      CMP_GREAT: begin
        dec_diff     = in_exp_B - in_exp_A;
        dec_target_a = 1'b1;
        dec_exp      = in_exp_B;
      end
      CMP_EQUAL: ;
      CMP_ERROR: begin
        dec_err = 1'b1;
        dec_exp = '0;
      end
    endcase
    if ({1'b0, dec_diff} >= MAN_W_X) dec_cnt = CNT_W'(MAN_W);
    else                             dec_cnt = CNT_W'(dec_diff);
  end

  // Single shifter on whichever mantissa is the target.
  logic [MAN_W-1:0] step_in;
  logic [MAN_W-1:0] step_out;
  logic             step_sticky_in;
  logic             step_sticky_out;

  assign step_in = target_a ? out_man_A : out_man_B;

`ifdef ALIGN_STICKY_EN
  assign step_sticky_in = out_sticky;
`else
  assign step_sticky_in = 1'b0;
  logic unused_sticky;
  assign unused_sticky = step_sticky_out;
`endif

  align_shift_step #(.MAN_W(MAN_W)) u_step (
    .man_in     (step_in),
    .sticky_in  (step_sticky_in),
    .man_out    (step_out),
    .sticky_out (step_sticky_out)
  );

  assign in_ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      target_a   <= 1'b0;
      out_valid  <= 1'b0;
      out_exp    <= '0;
      out_man_A  <= '0;
      out_man_B  <= '0;
      out_err    <= 1'b0;
`ifdef ALIGN_STICKY_EN
      out_sticky <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            out_man_A  <= in_man_A;
            out_man_B  <= in_man_B;
            out_exp    <= dec_exp;
            out_err    <= dec_err;
            target_a   <= dec_target_a;
            cnt        <= dec_cnt;
`ifdef ALIGN_STICKY_EN
            out_sticky <= 1'b0;
`endif
            if (dec_cnt == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (target_a) out_man_A <= step_out;
          else          out_man_B <= step_out;
`ifdef ALIGN_STICKY_EN
          out_sticky <= step_sticky_out;
`endif
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Outputs hold until the downstream takes them.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_mantissa_aligner.md
Name: fp_mantissa_aligner

Overview:
- Consumes the 2-bit exponent-compare code from the exponent comparator, together with both operands' exponents and mantissas.
- Right-shifts the mantissa of the smaller-exponent operand, one bit per cycle, until both mantissas share the larger exponent.
- Sits between the comparator and the mantissa adder in the FP add/sub datapath.
- Uses a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 24, mantissa width including the hidden bit.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept an operand set.
- in_code  input  2  compare code: 00 EQUAL, 01 GREAT (exp_A < exp_B), 10 SMALL (exp_A > exp_B), 11 ERROR.
- in_exp_A, in_exp_B  input  EXP_W  operand exponents.
- in_man_A, in_man_B  input  MAN_W  operand mantissas.
- out_valid  output  1  aligned result valid.
- out_ready  input  1  downstream accepts the result.
- out_exp  output  EXP_W  common (larger) exponent.
- out_man_A, out_man_B  output  MAN_W  aligned mantissas.
- out_err  output  1  input code was ERROR.

Behaviour:
- One clock domain (clk). rst_n is asynchronous, active-low.
- Reset forces state IDLE; out_valid=0, out_exp=0, out_man_A=0, out_man_B=0, out_err=0, internal counter=0.
- in_ready = (state==IDLE), so it reads 1 during and immediately after reset.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE, on in_valid && in_ready (accept edge t): latch all inputs.
  - Code 10: diff = exp_A - exp_B, shift target B, out_exp = exp_A.
  - Code 01: diff = exp_B - exp_A, shift target A, out_exp = exp_B.
  - Code 00: diff = 0, out_exp = exp_A.
  - Code 11: diff = 0, out_err = 1, out_exp = 0, mantissas passed unchanged.
  - Shift count n = min(diff, MAN_W), unsigned, computed in EXP_W bits.
  - The block trusts the code; it does not re-compare the exponents.
  - Next state: n==0 -> DONE; otherwise SHIFT with cnt=n.
- SHIFT, every edge: target mantissa logical-right-shifted by 1 (zero fill), cnt--.
  - When cnt==1 before the edge, next state is DONE.
  - in_valid is ignored while in SHIFT.
- DONE: out_valid=1; all outputs held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE and drop out_valid.
  - No accept in the same cycle as a transfer.
- Latency: out_valid rises on edge t+n, i.e. n+1 cycles after the input is presented. Minimum 1 cycle, maximum MAN_W+1.
- Throughput: one operand set per n+2 cycles, at best.
- diff >= MAN_W saturates: target mantissa becomes all-zero after MAN_W shifts.
- Exponent 0 operands get no special treatment.
- rst_n asserted mid-SHIFT or mid-DONE: immediate abort to the reset values, and the in-flight operand is lost.

Optional Feature:
- ALIGN_STICKY_EN defined:
  - Extra port out_sticky (output, 1) = OR of every bit shifted out of the target mantissa, reset 0 and cleared on accept.
  - Under saturation it equals the OR of the original target mantissa.
- ALIGN_STICKY_EN undefined: the port and its logic are absent and shifted-out bits are discarded.

Decomposition:
- Shared package fp_pkg holds:
  - Compare-code constants CMP_EQUAL=2'b00, CMP_GREAT=2'b01, CMP_SMALL=2'b10, CMP_ERROR=2'b11 (shared with the comparator).
  - FSM state encoding IDLE/SHIFT/DONE.
  - Default EXP_W and MAN_W.
- Counter width is clog2(MAN_W+1), local to the block.
- Natural sub-module: align_shift_step, a combinational single-bit right shift with sticky accumulate, instantiated once on the target-mantissa path.

Test Plan (all scenarios use EXP_W=8, MAN_W=24):
- Equal exponents: code 00, expA=expB=0x80, manA=0xC00000, manB=0x800000 -> out_valid 1 cycle after accept; mantissas unchanged; out_exp=0x80; out_sticky=0.
- A larger: code 10, expA=0x83, expB=0x80, manB=0x800001 -> out_valid 4 cycles after accept; out_man_B=0x100000; out_man_A unchanged; out_exp=0x83; out_sticky=1.
- Saturation: code 01, expA=0x10, expB=0x50, manA=0xFFFFFF -> out_valid 25 cycles after accept; out_man_A=0; out_exp=0x50; out_sticky=1.
- Error code: code 11, arbitrary operands -> out_valid 1 cycle after accept; out_err=1; out_exp=0; mantissas unchanged; the next accepted operand set clears out_err.
- Backpressure: out_ready held 0 for 5 cycles in DONE while in_valid=1 -> outputs bit-stable; in_ready=0; no new accept until one cycle after the transfer.
- Reset abort: rst_n pulsed low mid-SHIFT (cnt=10) -> outputs zero immediately (asynchronous); in_ready=1; the next operand set is processed correctly after release.
